// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and frame constants for the instruction
// memory boot loader.
//   state_t        - loader FSM states
//   SYNC_BYTE      - frame start marker
//   LEN_W          - width of the little-endian word-count field
//   WORD_W / BPW   - instruction word width and bytes per word
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_W     = 16;
  localparam int         WORD_W    = 32;
  localparam int         BPW       = WORD_W / 8;
  localparam int         BCNT_W    = $clog2(BPW);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_ERROR
  } state_t;

  // States in which the loader is inside a frame waiting on the next byte;
  // only these are subject to the inter-byte timeout.
  function automatic logic waits_for_byte(input state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: loadable down-counter used as the inter-byte watchdog.
//   clk, reset_n - clock, async active-low reset
//   load         - reload to TIMEOUT (byte accepted or not waiting)
//   expired      - counter has run down to zero
// After a load, TIMEOUT further idle clocks are tolerated; expired is high
// from then on until the next load.
module loader_timeout #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          cnt <= CNT_W'(TIMEOUT);
    else if (load)         cnt <= CNT_W'(TIMEOUT);
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Receives frames  A5 | LEN_LO | LEN_HI | N*4 data bytes | CHK  over a
// valid/ready byte stream, assembles little-endian words and writes them to
// consecutive word addresses. The core is held in reset from the sync byte
// until a frame passes its checksum.
//   clk, reset_n           - clock, async active-low reset
//   rx_valid/rx_data/rx_ready - byte input handshake
//   im_ce/im_we/im_addr/im_d  - instruction memory write port
//   core_reset_n           - active-low reset to the core
//   busy/done/error        - frame in progress / accept pulse / sticky failure
// All outputs are registered.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_ce,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_d,
  output logic              core_reset_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_t              state;
  logic [LEN_W-1:0]    len;
  logic [7:0]          sum;
  logic [BCNT_W-1:0]   bcnt;
  logic [WORD_W-1:0]   wbuf;

  logic                accept;
  logic [7:0]          sum_n;
  logic [LEN_W-1:0]    len_full;
  logic                expired;
  logic                to_load;
  logic                go_err;
  logic                last_word;

  assign accept    = rx_valid & rx_ready;
  assign sum_n     = sum + rx_data;
  assign len_full  = {rx_data, len[7:0]};
  // len <= DEPTH here, so the extra bit keeps N == DEPTH from aliasing to 0.
  assign last_word = (({1'b0, im_addr} + 1'b1) == len[ADDR_W:0]);
  assign to_load   = accept | ~waits_for_byte(state);

  always_comb begin
    go_err = 1'b0;
    if (waits_for_byte(state) && !accept && expired)        go_err = 1'b1;
    if (state == ST_LEN_HI && accept && len_full > DEPTH_L)  go_err = 1'b1;
    if (state == ST_CHECK  && accept && sum_n != 8'h00)      go_err = 1'b1;
  end

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (to_load),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      len          <= '0;
      sum          <= '0;
      bcnt         <= '0;
      wbuf         <= '0;
      rx_ready     <= 1'b1;
      im_ce        <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_d         <= '0;
      core_reset_n <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go_err) begin
        state    <= ST_ERROR;
        rx_ready <= 1'b0;
        error    <= 1'b1;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (accept && rx_data == SYNC_BYTE) begin
              state        <= ST_LEN_LO;
              busy         <= 1'b1;
              core_reset_n <= 1'b0;
              error        <= 1'b0;
              sum          <= '0;
              im_addr      <= '0;
              bcnt         <= '0;
            end
          end
          ST_LEN_LO: begin
            if (accept) begin
              len[7:0] <= rx_data;
              sum      <= sum_n;
              state    <= ST_LEN_HI;
            end
          end
          ST_LEN_HI: begin
            if (accept) begin
              len   <= len_full;
              sum   <= sum_n;
              state <= (len_full == '0) ? ST_CHECK : ST_DATA;
            end
          end
          ST_DATA: begin
            if (accept) begin
              // First byte ends up in [7:0] after four shifts.
              wbuf <= {rx_data, wbuf[WORD_W-1:8]};
              sum  <= sum_n;
              bcnt <= bcnt + 1'b1;
              if (bcnt == BCNT_W'(BPW - 1)) begin
                state    <= ST_WRITE;
                rx_ready <= 1'b0;
                im_ce    <= 1'b1;
                im_we    <= 1'b1;
                im_d     <= {rx_data, wbuf[WORD_W-1:8]};
              end
            end
          end
          ST_WRITE: begin
            im_ce    <= 1'b0;
            im_we    <= 1'b0;
            rx_ready <= 1'b1;
            im_addr  <= im_addr + 1'b1;
            state    <= last_word ? ST_CHECK : ST_DATA;
          end
          ST_CHECK: begin
            // A bad checksum is routed to ERROR by go_err.
            if (accept) begin
              state        <= ST_IDLE;
              done         <= 1'b1;
              core_reset_n <= 1'b1;
              busy         <= 1'b0;
            end
          end
          ST_ERROR: begin
            state    <= ST_IDLE;
            rx_ready <= 1'b1;
          end
          default: begin
            state    <= ST_IDLE;
            rx_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              im_ce;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_d;
  logic              core_reset_n;
  logic              busy;
  logic              done;
  logic              error;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .im_ce        (im_ce),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_d         (im_d),
    .core_reset_n (core_reset_n),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          errors = 0;
  int          checks = 0;
  int          wr_count = 0;
  int          done_count = 0;
  logic [31:0] words [DEPTH];

  // Write-port scoreboard: every strobe must match the next queued word,
  // and the byte input must be stalled during the strobe cycle.
  always @(negedge clk) begin
    if (done) done_count++;
    if (im_we) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", im_addr, im_d);
      end else begin
        mon_e = exp_q.pop_front();
        if ({im_ce, rx_ready, im_addr, im_d} !== {1'b1, 1'b0, mon_e.addr, mon_e.data}) begin
          errors++;
          $display("FAIL write got ce=%b rdy=%b addr=%0d d=%h exp ce=1 rdy=0 addr=%0d d=%h",
                   im_ce, rx_ready, im_addr, im_d, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    int   n;
    n = 0;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    forever begin
      ok = rx_ready;
      @(posedge clk);
      n++;
      if (ok || n > 50) break;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_byte %h not accepted in 50 cycles", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends a frame of n words from words[]; queues the expected writes and
  // computes CHK so the byte sum is zero, or off by one when bad is set.
  task automatic send_frame(input int n, input bit bad);
    logic [7:0] s;
    logic [7:0] b;
    logic [7:0] chk;
    s = 8'h00;
    send_byte(SYNC_BYTE);
    checks++;
    if ({busy, core_reset_n, error} !== 3'b100) begin
      errors++;
      $display("FAIL sync busy/core_rst_n/err got=%b exp=100", {busy, core_reset_n, error});
    end
    b = 8'(n);      s = s + b; send_byte(b);
    b = 8'(n >> 8); s = s + b; send_byte(b);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({ADDR_W'(i), words[i]});
      for (int j = 0; j < 4; j++) begin
        b = words[i][8*j +: 8];
        s = s + b;
        send_byte(b);
      end
    end
    chk = 8'h00 - s;
    if (bad) chk = chk + 8'h01;
    send_byte(chk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_ready, im_ce, im_we, im_addr, im_d, core_reset_n, busy, done, error} !==
        {1'b1, 1'b0, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values rdy=%b ce=%b we=%b addr=%0d d=%h crn=%b busy=%b done=%b err=%b",
               rx_ready, im_ce, im_we, im_addr, im_d, core_reset_n, busy, done, error);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({wr_count, rx_ready, core_reset_n} !== {32'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle wr=%0d rdy=%b crn=%b exp wr=0 rdy=1 crn=0", wr_count, rx_ready, core_reset_n);
    end
  endtask

  task automatic test_good_frame();
    int d0;
    d0 = done_count;
    words[0] = 32'h0000_0013;
    words[1] = 32'h0000_006F;
    send_frame(2, 1'b0);
    checks++;
    if ({done, core_reset_n, busy, error} !== 4'b1100) begin
      errors++;
      $display("FAIL good_complete done/crn/busy/err got=%b exp=1100", {done, core_reset_n, busy, error});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || done_count != d0 + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL good_after done=%b pulses=%0d pending=%0d exp done=0 pulses=1 pending=0",
               done, done_count - d0, exp_q.size());
    end
  endtask

  task automatic test_bad_chk();
    int d0, wc;
    d0 = done_count;
    wc = wr_count;
    send_frame(2, 1'b1);
    checks++;
    if ({error, busy, core_reset_n, rx_ready, done} !== 5'b10000) begin
      errors++;
      $display("FAIL badchk err/busy/crn/rdy/done got=%b exp=10000",
               {error, busy, core_reset_n, rx_ready, done});
    end
    @(negedge clk);
    checks++;
    if ({error, rx_ready, core_reset_n} !== 3'b110 || wr_count != wc + 2 ||
        done_count != d0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL badchk_after err/rdy/crn=%b writes=%0d dones=%0d pending=%0d exp 110 2 0 0",
               {error, rx_ready, core_reset_n}, wr_count - wc, done_count - d0, exp_q.size());
    end
  endtask

  task automatic test_len_too_big();
    int wc;
    wc = wr_count;
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    send_byte(8'h04);
    checks++;
    if ({error, busy} !== 2'b10) begin
      errors++;
      $display("FAIL len_big err/busy got=%b exp=10", {error, busy});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_count != wc) begin
      errors++;
      $display("FAIL len_big_writes got=%0d exp=0", wr_count - wc);
    end
    words[0] = $urandom;
    send_frame(1, 1'b0);
    checks++;
    if ({done, core_reset_n, error} !== 3'b110) begin
      errors++;
      $display("FAIL len_big_recover done/crn/err got=%b exp=110", {done, core_reset_n, error});
    end
  endtask

  task automatic test_timeout();
    int wc, n;
    wc = wr_count;
    send_byte(SYNC_BYTE);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TIMEOUT) @(negedge clk);
    checks++;
    if ({error, busy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_early err/busy got=%b exp=01", {error, busy});
    end
    n = 0;
    while (error !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({error, busy, core_reset_n} !== 3'b100 || n > 1 || wr_count != wc) begin
      errors++;
      $display("FAIL timeout err/busy/crn=%b extra_cycles=%0d writes=%0d exp 100 1 0",
               {error, busy, core_reset_n}, n, wr_count - wc);
    end
    @(negedge clk);
  endtask

  task automatic test_garbage_n0();
    int d0;
    logic [7:0] g [3];
    g[0] = 8'h00; g[1] = 8'hFF; g[2] = 8'hA4;
    d0 = done_count;
    for (int i = 0; i < 3; i++) begin
      send_byte(g[i]);
      checks++;
      if ({busy, error} !== 2'b01) begin
        errors++;
        $display("FAIL garbage_%0d busy/err got=%b exp=01", i, {busy, error});
      end
    end
    send_frame(0, 1'b0);
    checks++;
    if ({done, core_reset_n, busy, error} !== 4'b1100) begin
      errors++;
      $display("FAIL n0_frame done/crn/busy/err got=%b exp=1100", {done, core_reset_n, busy, error});
    end
    @(negedge clk);
    checks++;
    if (done_count != d0 + 1) begin
      errors++;
      $display("FAIL n0_done_pulses got=%0d exp=1", done_count - d0);
    end
  endtask

  task automatic test_full_depth();
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    send_frame(DEPTH, 1'b0);
    checks++;
    if ({done, core_reset_n, error} !== 3'b110 || im_addr !== '0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_depth done/crn/err=%b addr=%0d pending=%0d exp 110 0 0",
               {done, core_reset_n, error}, im_addr, exp_q.size());
    end
  endtask

  task automatic test_midframe_reset();
    int wc;
    wc = wr_count;
    send_byte(SYNC_BYTE);
    checks++;
    if ({core_reset_n, busy} !== 2'b01) begin
      errors++;
      $display("FAIL sync_latency crn/busy got=%b exp=01", {core_reset_n, busy});
    end
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rx_ready, im_ce, im_we, im_addr, im_d, core_reset_n, busy, done, error} !==
        {1'b1, 1'b0, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset rdy=%b ce=%b we=%b addr=%0d d=%h crn=%b busy=%b done=%b err=%b",
               rx_ready, im_ce, im_we, im_addr, im_d, core_reset_n, busy, done, error);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_count != wc || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after writes=%0d busy=%b exp 0 0", wr_count - wc, busy);
    end
    words[0] = 32'hDEAD_BEEF;
    send_frame(1, 1'b0);
    checks++;
    if ({done, core_reset_n} !== 2'b11 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_recover done/crn=%b pending=%0d exp 11 0", {done, core_reset_n}, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_too_big();
    test_timeout();
    test_garbage_n0();
    test_full_depth();
    test_midframe_reset();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
